sprite_line_buffer: RTL

SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

---
 rtl/sprite_line_buffer_if.sv | 27 ++
 rtl/sprite_line_buffer.sv | 119 +++++++++++
 2 files changed

// File: rtl/sprite_line_buffer_if.sv
// Sprite line buffer bus: renderer and display ports plus status.
// Shared by the buffer (slave) and whatever drives it (master).
interface sprite_line_buffer_if;
   logic        buf_swap;
   logic [9:0]  rend_rdidx;
   logic [15:0] rend_rddata;
   logic [9:0]  rend_wridx;
   logic [15:0] rend_wrdata;
   logic        rend_wren;
   logic [9:0]  disp_rdidx;
   logic        disp_rden;
   logic [15:0] disp_rddata;
   logic        clr_busy;
   logic        clear_overrun;

   modport slave (
      input  buf_swap, rend_rdidx, rend_wridx, rend_wrdata, rend_wren,
      input  disp_rdidx, disp_rden,
      output rend_rddata, disp_rddata, clr_busy, clear_overrun
   );

   modport master (
      output buf_swap, rend_rdidx, rend_wridx, rend_wrdata, rend_wren,
      output disp_rdidx, disp_rden,
      input  rend_rddata, disp_rddata, clr_busy, clear_overrun
   );
endinterface

// File: rtl/sprite_line_buffer.sv
// Double-banked sprite line buffer with clear-on-read display side,
// tail sweep of the invisible region and a power-up clear of both banks.
module sprite_line_buffer #(
   parameter int ACTIVE_WIDTH = 640,
   parameter int DEPTH        = 1024
) (
   input logic                  clk,
   input logic                  rst,
   sprite_line_buffer_if.slave  bus
);
   localparam logic [1:0]  S_INIT  = 2'd0;
   localparam logic [1:0]  S_IDLE  = 2'd1;
   localparam logic [1:0]  S_SWEEP = 2'd2;

   localparam logic [9:0]  LAST = 10'(DEPTH - 1);
   localparam logic [9:0]  AW10 = 10'(ACTIVE_WIDTH);
   localparam logic [10:0] AW11 = 11'(ACTIVE_WIDTH);

   logic [15:0] mem0 [DEPTH];
   logic [15:0] mem1 [DEPTH];

   logic [1:0]  st;
   logic [9:0]  cnt;
   logic        bank_r;
   logic        pend;
   logic [9:0]  pend_idx;
   logic        pend_bank;
   logic        ovr;
   logic [15:0] rend_q;
   logic [15:0] disp_q;
   logic        in_init;
   logic        vis;

   assign in_init = (st == S_INIT);
   assign vis     = ({1'b0, bus.disp_rdidx} < AW11);

   assign bus.rend_rddata   = rend_q;
   assign bus.disp_rddata   = disp_q;
   assign bus.clr_busy      = (st != S_IDLE);
   assign bus.clear_overrun = ovr;

   // Bank storage: init clear, deferred read clear or sweep, render write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (in_init) begin
            mem0[cnt] <= '0;
            mem1[cnt] <= '0;
         end else begin
            if (pend) begin
               if (pend_bank) mem1[pend_idx] <= '0;
               else           mem0[pend_idx] <= '0;
            end else if (st == S_SWEEP) begin
               if (bank_r) mem0[cnt] <= '0;
               else        mem1[cnt] <= '0;
            end
            if (bus.rend_wren) begin
               if (bank_r) mem1[bus.rend_wridx] <= bus.rend_wrdata;
               else        mem0[bus.rend_wridx] <= bus.rend_wrdata;
            end
         end
      end
   end

   // Registered read ports; both read as zero while initialising.
   always_ff @(posedge clk) begin
      if (rst || in_init) begin
         rend_q <= '0;
         disp_q <= '0;
      end else begin
         rend_q <= bank_r ? mem1[bus.rend_rdidx] : mem0[bus.rend_rdidx];
         if (bus.disp_rden)
            disp_q <= bank_r ? mem0[bus.disp_rdidx] : mem1[bus.disp_rdidx];
      end
   end

   // Clear sequencer: init sweep, tail sweep, bank swap, pending clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_INIT;
         cnt       <= '0;
         bank_r    <= 1'b0;
         pend      <= 1'b0;
         pend_idx  <= '0;
         pend_bank <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         ovr  <= 1'b0;
         pend <= 1'b0;
         unique case (st)
            S_INIT: begin
               if (cnt == LAST) begin
                  st  <= S_IDLE;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            S_SWEEP: begin
               if (!pend) begin
                  if (cnt == LAST) st <= S_IDLE;
                  else             cnt <= cnt + 10'd1;
               end
            end
            default: ;
         endcase
         if (!in_init) begin
            pend      <= bus.disp_rden && vis;
            pend_idx  <= bus.disp_rdidx;
            pend_bank <= ~bank_r;
            if (bus.buf_swap) begin
               bank_r <= ~bank_r;
               cnt    <= AW10;
               st     <= S_SWEEP;
               ovr    <= (st == S_SWEEP);
            end
         end
      end
   end
endmodule
